bundle_packer: RTL
==================

BUNDLE_PACKER -- requirements
Module: bundle_packer

Interface
REQ-001 SHALL have parameter PAD_TIMEOUT, default 4, range 1..15: idle cycles a lone held instruction waits before it is emitted with a NOP partner.
REQ-002 SHALL have one clock and a synchronous, active-high reset; all state updates on posedge clock_i.
REQ-003 Ports:
- clock_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- enable_i  in  1  input instruction valid.
- isBranch_i  in  1  branch flag.
- instructionFormat_i  in  1  0 = 19b, 1 = 30b.
- opcode_i  in  7  opcode.
- reg_i  in  5  first register operand.
- operand_i  in  16  immediate (30b) or register in [4:0] (19b).
- ready_o  out  1  instruction accepted this cycle when enable_i && ready_o.
- stall_i  in  1  downstream stall.
- flushBack_i  in  1  pipeline flush.
- instruction_o  out  60  packed bundle.
- enable_o  out  1  bundle valid.

Function
REQ-004 SHALL pack two instructions per 60-bit bundle, in arrival order: first = slot 1, second = slot 2.
REQ-005 Slot 1 layout SHALL be: [59] format, [58] branch, [57:51] opcode, [50:46] reg.
REQ-006 Slot 1 operand and slot 2 base SHALL depend on slot 1 format:
- 30b: operand [45:30] = operand_i[15:0]; slot 2 base = bit 29.
- 19b: operand [45:41] = operand_i[4:0]; slot 2 base = bit 40.
REQ-007 Slot 2 layout, relative to base b, SHALL be: [b] format, [b-1] branch, [b-2:b-8] opcode, [b-9:b-13] reg, then a 16-bit operand field [b-14:b-29].
REQ-008 Slot 2 operand field SHALL be operand_i[15:0] if 30b, else {operand_i[4:0], 11'b0}.
REQ-009 All bundle bits not assigned by REQ-005..REQ-008 SHALL be 0.
REQ-010 NOP SHALL be format 0, branch 0, opcode 0, reg 0, operand 0.
REQ-011 Internal holding slot A SHALL have states EMPTY and HALF; the output register holds instruction_o/enable_o.
REQ-012 Let out_free = !enable_o || !stall_i. While enable_o=1 and stall_i=1, instruction_o and enable_o SHALL hold.
REQ-013 ready_o SHALL be combinational: 1 when EMPTY, or when HALF && out_free && slot A is not a branch; else 0.
REQ-014 EMPTY + accept SHALL store the instruction in slot A and move to HALF; the timeout counter clears.
REQ-015 HALF + accept SHALL load the bundle {slot A, new} into the output register at that edge: enable_o=1 the next cycle; move to EMPTY.
REQ-016 HALF with a branch in slot A SHALL emit {slot A, NOP} at the first edge with out_free=1; move to EMPTY.
REQ-017 HALF with a non-branch in slot A and no accept SHALL increment the counter, saturating at PAD_TIMEOUT.
REQ-018 When counter == PAD_TIMEOUT and out_free=1, the block SHALL emit {slot A, NOP} and move to EMPTY.
REQ-019 An accept in the same cycle as a timeout SHALL win: pair the instruction, no pad.
REQ-020 When out_free=1 and no bundle is loaded, enable_o SHALL go to 0 at the next edge.
REQ-021 A branch arriving as slot 2 SHALL pair normally.
REQ-022 flushBack_i=1 SHALL, at that edge, take priority over all else:
- enable_o <= 0
- slot A -> EMPTY
- counter <= 0
- any concurrently accepted instruction discarded.
instruction_o SHALL be unchanged.

Reset
REQ-023 reset_i=1 SHALL, at the edge, set instruction_o=0, enable_o=0, slot A EMPTY, counter=0; reset_i SHALL take priority over flushBack_i.
REQ-024 During reset, ready_o SHALL read 1, but no instruction accepted in a reset cycle SHALL be stored.

Verification
REQ-025 Bench SHALL cover:
- Pair, 19b first: A = {fmt0, br0, op 7'h05, reg 3, opnd 9}, then B = {fmt1, br0, op 7'h11, reg 7, opnd 16'hBEEF} on consecutive cycles -> one cycle after B: enable_o=1, [59]=0, [45:41]=9, [40]=1, [26:11]=16'hBEEF, [10:0]=0.
- Pair, 30b first: A = {fmt1, opnd 16'h1234}, B = {fmt0, opnd 5'h1F} -> [45:30]=16'h1234, [29]=0, [15:11]=5'h1F, [10:0]=0.
- Timeout: one non-branch, then idle with PAD_TIMEOUT=4 -> padded bundle loaded at the 5th edge after accept; slot 2 all zero.
- Branch: branch accepted while EMPTY -> ready_o=0 the next cycle; {branch, NOP} emitted at that cycle's edge with enable_o=1; a stall_i=1 during that window delays emission and holds instruction_o stable.
- Stall: stall_i=1 with enable_o=1 for 3 cycles plus a third instruction arriving in HALF -> ready_o=0, instruction_o unchanged, no instruction lost after release.
- Flush/reset: flushBack_i (or reset_i) in HALF with a simultaneous accept -> enable_o=0 and EMPTY next cycle; the next two instructions form a fresh bundle with the first in slot 1.

Source files
------------

// File: rtl/bundle_packer.sv
// bundle_packer: pairs incoming 19b/30b instructions into 60-bit bundles, padding lone ones with a NOP
module bundle_packer #(
   parameter int PAD_TIMEOUT = 4
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic        isBranch_i,
   input  logic        instructionFormat_i,
   input  logic [6:0]  opcode_i,
   input  logic [4:0]  reg_i,
   input  logic [15:0] operand_i,
   output logic        ready_o,
   input  logic        stall_i,
   input  logic        flushBack_i,
   output logic [59:0] instruction_o,
   output logic        enable_o
);
   typedef enum logic {EMPTY, HALF} state_t;
   typedef struct packed {
      logic        fmt;
      logic        br;
      logic [6:0]  op;
      logic [4:0]  rg;
      logic [15:0] opnd;
   } ins_t;
   localparam logic [3:0] PAD = 4'(PAD_TIMEOUT);
   state_t      state_q, state_d;
   ins_t        a_q, a_d, in_w;
   logic [3:0]  cnt_q, cnt_d;
   logic [59:0] out_q, out_d;
   logic        en_q, en_d, out_free, accept;
   function automatic logic [59:0] pack(input ins_t a, input ins_t b);
      logic [29:0] s2;
      s2 = {b.fmt, b.br, b.op, b.rg, b.fmt ? b.opnd : {b.opnd[4:0], 11'b0}};
      return a.fmt ? {a.fmt, a.br, a.op, a.rg, a.opnd, s2}
                   : {a.fmt, a.br, a.op, a.rg, a.opnd[4:0], s2, 11'b0};
   endfunction
   assign in_w          = '{instructionFormat_i, isBranch_i, opcode_i, reg_i, operand_i};
   assign out_free      = !en_q || !stall_i;
   assign ready_o       = reset_i || state_q == EMPTY || (out_free && !a_q.br);
   assign accept        = enable_i && ready_o;
   assign instruction_o = out_q;
   assign enable_o      = en_q;
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      en_d    = out_free ? 1'b0 : en_q;
      if (state_q == EMPTY) begin
         if (accept) begin
            state_d = HALF;
            a_d     = in_w;
            cnt_d   = '0;
         end
      end else if (accept || (out_free && (a_q.br || cnt_q == PAD))) begin
         out_d   = pack(a_q, accept ? in_w : '0);
         en_d    = 1'b1;
         state_d = EMPTY;
         cnt_d   = '0;
      end else if (!a_q.br && cnt_q != PAD) begin
         cnt_d = cnt_q + 4'd1;
      end
      if (flushBack_i) begin
         en_d    = 1'b0;
         state_d = EMPTY;
         cnt_d   = '0;
         out_d   = out_q;
      end
   end
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= EMPTY;
         a_q     <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         en_q    <= en_d;
      end
   end
endmodule
